fib_iter_adder: RTL and testbench
=================================

# fib_iter_adder

Parametrised, sequential Fibonacci-recurrence engine for the CAC Fibonacci-numeral encode/decode path. It replaces a chain of fixed-width, single-stage combinational Fibonacci adders with one W-bit adder/subtractor iterated over STEPS cycles. Each step honours a per-step error flag: a flagged step holds the pair instead of advancing. It supports forward generation, f(k)=f(k-1)+f(k-2), and reverse walk-back, f(k-2)=f(k)-f(k-1), and reports a sticky overflow/borrow flag.

## Interface
- W, default 8: operand/result width, W >= 2.
- STEPS, default 8: recurrence steps per job, STEPS >= 1. The step counter width is derived internally as clog2(STEPS+1).
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_in  input  1  job request; sampled only when busy_out=0.
- mode_in  input  1  0 = forward (add), 1 = reverse (subtract); latched at accept.
- a_in  input  W  seed f(k-2) in forward mode, f(k-1) in reverse mode.
- b_in  input  W  seed f(k-1) in forward mode, f(k) in reverse mode.
- err_mask_in  input  STEPS  per-step error flags, bit i applies to step i, 1 = hold; latched at accept.
- busy_out  output  1  high while a job is running.
- done_out  output  1  one-cycle pulse when results are final.
- s_out  output  W  newest term, from the B register.
- b_out  output  W  previous term, from the A register.
- ovf_out  output  1  sticky carry-out (forward) or borrow (reverse) for the current job.

## Operation
- Internal registers: A, B (W bits each), step counter cnt, latched mode, latched mask. All outputs are registered.
- States:
  - IDLE: busy_out=0, done_out=0.
  - RUN: busy_out=1.
  - DONE: busy_out=0, done_out=1, lasts exactly one cycle, then IDLE.
- Accept: start_in=1 while in IDLE or DONE. On that edge:
  - A<=a_in, B<=b_in, cnt<=0, ovf<=0.
  - mode_in and err_mask_in are latched.
  - State becomes RUN.
- start_in while in RUN is ignored; no queueing.
- RUN, one step per cycle, step i = cnt:
  - mask[i]=1: A and B hold; ovf is unchanged.
  - Forward, mask[i]=0: A<=B; B<=(A+B) mod 2^W; ovf<=ovf | carry-out.
  - Reverse, mask[i]=0: B<=A; A<=(B-A) mod 2^W; ovf<=ovf | (B<A).
  - cnt increments each step. On the step with cnt=STEPS-1, the state goes to DONE.
- s_out/b_out track B/A continuously, including mid-job. They are only guaranteed final while done_out=1. They hold their final values through IDLE until the next accept.
- Arithmetic is unsigned modulo 2^W. Wrap-around is not saturated; it is only flagged through ovf_out.
- An all-ones mask gives s_out=b_in, b_out=a_in, ovf_out=0.

## Timing
- Reset: state IDLE, A=B=0, cnt=0. Every output is 0 (busy_out, done_out, s_out, b_out, ovf_out).
- Reset has priority over start_in and over any in-progress step.
- Reset mid-RUN aborts the job: no done_out pulse is produced and the results are cleared to 0.
- Latency: if start is accepted at edge E, busy_out=1 from E through E+STEPS-1. done_out=1 in the cycle following edge E+STEPS, i.e. STEPS cycles after busy rises.
- Back-to-back: start_in=1 during the DONE cycle is accepted. busy_out returns to 1 on the next edge with no idle gap, and throughput is one job per STEPS+1 cycles.
- Seeds are taken only at the accept edge; changes to a_in/b_in/mode_in/err_mask_in during RUN have no effect.
- The ovf flag is cleared at each accept and is otherwise never cleared except by rst.

## Test plan
All scenarios use W=8, STEPS=8.
- Forward, no errors: a_in=0, b_in=1, mask=0x00, mode=0 -> done 8 cycles after busy rises; s_out=34, b_out=21, ovf_out=0.
- Forward, masked steps: a_in=0, b_in=1, mask=0x05 (steps 0 and 2 held) -> s_out=13, b_out=8, ovf_out=0; all-ones mask -> s_out=1, b_out=0.
- Overflow wrap: a_in=89, b_in=144, mask=0x00, mode=0 -> ovf_out=1 (set at step 1, stays set); s_out=109, b_out=85.
- Reverse walk-back: a_in=21, b_in=34, mode=1, mask=0x00 -> s_out=1, b_out=0, ovf_out=0; a_in=5, b_in=3, mode=1 -> ovf_out=1.
- Handshake: start_in held high for 20 cycles -> start re-accepted in each DONE cycle; done pulses exactly every 9 cycles; starts during RUN are ignored; changing a_in mid-run leaves the result unchanged.
- Reset mid-run: accept a job, assert rst on the 4th RUN cycle -> on the next edge all outputs are 0, no done_out pulse occurs, and a subsequent start runs a clean full job.

Source files
------------

// File: rtl/fib_iter_adder_if.sv
// Job handshake and result bus for the iterated Fibonacci adder.
// The design connects through the slave modport; the driver uses master.
interface fib_iter_adder_if #(
    parameter int W     = 8,
    parameter int STEPS = 8
);
    logic             start_in;
    logic             mode_in;
    logic [W-1:0]     a_in;
    logic [W-1:0]     b_in;
    logic [STEPS-1:0] err_mask_in;
    logic             busy_out;
    logic             done_out;
    logic [W-1:0]     s_out;
    logic [W-1:0]     b_out;
    logic             ovf_out;

    modport slave (
        input  start_in, mode_in, a_in, b_in, err_mask_in,
        output busy_out, done_out, s_out, b_out, ovf_out
    );

    modport master (
        output start_in, mode_in, a_in, b_in, err_mask_in,
        input  busy_out, done_out, s_out, b_out, ovf_out
    );
endinterface

// File: rtl/fib_iter_adder.sv
// Sequential Fibonacci-recurrence engine: one W-bit adder/subtractor iterated
// over STEPS cycles, forward (A+B) or reverse (B-A), with per-step hold flags.
module fib_iter_adder #(
    parameter int W     = 8,
    parameter int STEPS = 8
) (
    input  logic            clk,
    input  logic            rst,
    fib_iter_adder_if.slave bus
);
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_mode;
    logic [STEPS-1:0] r_mask;
    logic             r_ovf;
    logic             w_accept;
    logic             w_last;
    logic             w_busy;
    logic             w_done;
    logic [W:0]       w_sum;
    logic [W:0]       w_diff;

    // Top bit of the result is the carry-out (add) or borrow (subtract).
    function automatic logic [W:0] fwd_add(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [W:0] rev_sub(input logic [W-1:0] minuend, input logic [W-1:0] subtrahend);
        return {1'b0, minuend} - {1'b0, subtrahend};
    endfunction

    assign w_accept = bus.start_in && (r_state != S_RUN);
    assign w_last   = (r_cnt == CW'(STEPS - 1));
    assign w_sum    = fwd_add(r_a, r_b);
    assign w_diff   = rev_sub(r_b, r_a);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_last)   w_next = S_DONE;
            S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // The mask is shifted each step so bit 0 is always the current step's flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
            r_mask <= '0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a    <= bus.a_in;
            r_b    <= bus.b_in;
            r_cnt  <= '0;
            r_mode <= bus.mode_in;
            r_mask <= bus.err_mask_in;
            r_ovf  <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_cnt  <= r_cnt + CW'(1);
            r_mask <= r_mask >> 1;
            if (!r_mask[0]) begin
                if (r_mode) begin
                    r_b   <= r_a;
                    r_a   <= w_diff[W-1:0];
                    r_ovf <= r_ovf | w_diff[W];
                end else begin
                    r_a   <= r_b;
                    r_b   <= w_sum[W-1:0];
                    r_ovf <= r_ovf | w_sum[W];
                end
            end
        end
    end

    assign bus.busy_out = w_busy;
    assign bus.done_out = w_done;
    assign bus.s_out    = r_b;
    assign bus.b_out    = r_a;
    assign bus.ovf_out  = r_ovf;
endmodule

// File: tb/tb_fib_iter_adder.sv
// Directed bench for fib_iter_adder at W=8, STEPS=8 with hand-computed results.
module tb_fib_iter_adder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fib_iter_adder_if #(.W(8), .STEPS(8)) bus ();

    fib_iter_adder #(.W(8), .STEPS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are sampled on falling edges.
    task automatic run_job(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic mode, input logic [7:0] mask,
                           input logic [7:0] exp_s, input logic [7:0] exp_b, input logic exp_ovf);
        int cycles;
        bus.a_in        = a;
        bus.b_in        = b;
        bus.mode_in     = mode;
        bus.err_mask_in = mask;
        bus.start_in    = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        cycles = 0;
        while (!bus.done_out && cycles < 20) begin
            cycles++;
            @(negedge clk);
        end
        check({tag, "_lat"},  cycles, 8);
        check({tag, "_s"},    bus.s_out, exp_s);
        check({tag, "_b"},    bus.b_out, exp_b);
        check({tag, "_ovf"},  bus.ovf_out, exp_ovf);
        check({tag, "_busy"}, bus.busy_out, 0);
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        int last_t;
        int done_seen;
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.start_in    = 1'b0;
        bus.mode_in     = 1'b0;
        bus.a_in        = 8'd0;
        bus.b_in        = 8'd0;
        bus.err_mask_in = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy_out, 0);
        check("rst_done", bus.done_out, 0);
        check("rst_s",    bus.s_out, 0);
        check("rst_b",    bus.b_out, 0);
        check("rst_ovf",  bus.ovf_out, 0);
        rst = 1'b0;
        @(negedge clk);

        run_job("fwd",     8'd0,  8'd1,   1'b0, 8'h00, 8'd34,  8'd21,  1'b0);
        run_job("fwdmask", 8'd0,  8'd1,   1'b0, 8'h05, 8'd13,  8'd8,   1'b0);
        run_job("allmask", 8'd0,  8'd1,   1'b0, 8'hFF, 8'd1,   8'd0,   1'b0);
        run_job("ovf",     8'd89, 8'd144, 1'b0, 8'h00, 8'd109, 8'd85,  1'b1);
        run_job("rev",     8'd21, 8'd34,  1'b1, 8'h00, 8'd1,   8'd0,   1'b0);
        run_job("revbrw",  8'd5,  8'd3,   1'b1, 8'h00, 8'd190, 8'd107, 1'b1);
        run_job("clr",     8'd0,  8'd1,   1'b0, 8'h00, 8'd34,  8'd21,  1'b0);

        // Seeds altered and start pulsed mid-run must not disturb the job.
        bus.a_in = 8'd0; bus.b_in = 8'd1; bus.mode_in = 1'b0; bus.err_mask_in = 8'h00;
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.a_in = 8'd77; bus.b_in = 8'd99; bus.mode_in = 1'b1; bus.err_mask_in = 8'hFF;
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12 && !done_seen; i++) begin
            if (bus.done_out) done_seen = 1;
            else @(negedge clk);
        end
        check("midrun_done", done_seen, 1);
        check("midrun_s", bus.s_out, 34);
        check("midrun_b", bus.b_out, 21);
        @(negedge clk);
        check("midrun_noreq", bus.busy_out, 0);

        // Start held high: back-to-back jobs, done every 9 cycles.
        bus.a_in = 8'd0; bus.b_in = 8'd1; bus.mode_in = 1'b0; bus.err_mask_in = 8'h00;
        bus.start_in = 1'b1;
        pulses = 0;
        last_t = 0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (bus.done_out) begin
                pulses++;
                check("b2b_gap", t - last_t, 9);
                check("b2b_s", bus.s_out, 34);
                last_t = t;
            end
        end
        check("b2b_pulses", pulses, 4);
        bus.start_in = 1'b0;
        repeat (12) @(negedge clk);
        check("b2b_idle", bus.busy_out, 0);

        // Reset during the 4th RUN cycle aborts the job.
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.busy_out, 0);
        check("abort_s",    bus.s_out, 0);
        check("abort_b",    bus.b_out, 0);
        check("abort_ovf",  bus.ovf_out, 0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done_out) done_seen = 1;
            @(negedge clk);
        end
        check("abort_nodone", done_seen, 0);
        run_job("postrst", 8'd0, 8'd1, 1'b0, 8'h00, 8'd34, 8'd21, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
